// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline types, defaults and field widths for the fetch stage
package rv_pipe_pkg;
   localparam int PC_W = 32;
   localparam int INSTR_W = 32;
   localparam int COUNT_W = 16;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = '0;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = '0;
   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
   function automatic logic pc_bad(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] max_pc);
      return (pc[1:0] != 2'b00) || (pc > max_pc);
   endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls (bubble wins over load)
module if_id_reg
   import rv_pipe_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               bubble,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic               valid
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (bubble) begin
         pc    <= pc_in;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         pc    <= pc_in;
         instr <= instr_in;
         valid <= 1'b1;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and BOOT/RUN/HALT sequencer feeding the IF/ID register
module fetch_unit
   import rv_pipe_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [PC_W-1:0]    MAX_PC    = 32'h0000_003C,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    br_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    ifid_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic               ifid_valid,
   output logic               fetch_fault,
   output logic [COUNT_W-1:0] fetch_count
);
   fetch_state_t state, state_n;
   logic [PC_W-1:0] pc, pc_n;
   logic load, bubble, fault_set, count_en;

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         fetch_fault <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         fetch_fault <= fetch_fault | fault_set;
         fetch_count <= (count_en && fetch_count != '1) ? fetch_count + 1'b1 : fetch_count;
      end
   end

   // In RUN: flush redirects first, a stall freezes, otherwise the PC is checked before it is fetched
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      load      = 1'b0;
      bubble    = 1'b0;
      fault_set = 1'b0;
      count_en  = 1'b0;
      case (state)
         BOOT: begin
            bubble  = 1'b1;
            state_n = RUN;
         end
         RUN: begin
            if (flush) begin
               pc_n   = br_target;
               bubble = 1'b1;
            end else if (!stall) begin
               if (pc_bad(pc, MAX_PC)) begin
                  state_n   = HALT;
                  fault_set = 1'b1;
                  bubble    = 1'b1;
               end else begin
                  pc_n     = pc + 32'd4;
                  load     = 1'b1;
                  count_en = 1'b1;
               end
            end
         end
         default: begin
            bubble  = 1'b1;
            state_n = HALT;
         end
      endcase
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .bubble   (bubble),
      .pc_in    (pc),
      .instr_in (imem_rdata),
      .pc       (ifid_pc),
      .instr    (ifid_instr),
      .valid    (ifid_valid)
   );
endmodule
